// File: rtl/tile_op_sequencer_if.sv
// Command, bias-stream and array-control signals between the tile sequencer
// (master) and the host / systolic array side (slave).
interface tile_op_sequencer_if #(
  parameter int unsigned ARRAY_N      = 16,
  parameter int unsigned ARRAY_M      = 16,
  parameter int unsigned PE_OUT_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH   = 10
);
  localparam int unsigned ROW_W = $clog2(ARRAY_N) + 1;
  localparam int unsigned COL_W = $clog2(ARRAY_M) + 1;

  logic                    start;
  logic [ROW_W-1:0]        cfg_rows;
  logic [COL_W-1:0]        cfg_cols;
  logic [31:0]             cfg_k;
  logic                    cfg_bias_en;
  logic [ADDR_WIDTH-1:0]   cfg_a_base;
  logic [ADDR_WIDTH-1:0]   cfg_w_base;
  logic [ADDR_WIDTH-1:0]   cfg_o_base;
  logic [ADDR_WIDTH-1:0]   cfg_xfer_a_base;
  logic [PE_OUT_WIDTH-1:0] bias_data;
  logic                    bias_valid;
  logic                    bias_ready;
  logic                    Intra_sig_end;
  logic                    mode;
  logic                    a_buf_on;
  logic                    w_buf_on;
  logic [ADDR_WIDTH-1:0]   a_base_addr;
  logic [ADDR_WIDTH-1:0]   w_base_addr;
  logic [ADDR_WIDTH-1:0]   o_base_addr;
  logic [ADDR_WIDTH-1:0]   Intra_O_base_addr;
  logic [ADDR_WIDTH-1:0]   Intra_A_base_addr;
  logic [ROW_W-1:0]        a_num_rows;
  logic [COL_W-1:0]        w_num_cols;
  logic [2:0]              operation_signal_in;
  logic                    w_en_bias;
  logic [COL_W-1:0]        w_index_bias;
  logic [PE_OUT_WIDTH-1:0] w_data_bias;
  logic                    o_ag_o_on;
  logic                    sa_reset;
  logic                    Intranet_on;
  logic                    Intra_sig_start;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    input  start, cfg_rows, cfg_cols, cfg_k, cfg_bias_en, cfg_a_base, cfg_w_base,
           cfg_o_base, cfg_xfer_a_base, bias_data, bias_valid, Intra_sig_end,
    output bias_ready, mode, a_buf_on, w_buf_on, a_base_addr, w_base_addr, o_base_addr,
           Intra_O_base_addr, Intra_A_base_addr, a_num_rows, w_num_cols,
           operation_signal_in, w_en_bias, w_index_bias, w_data_bias, o_ag_o_on,
           sa_reset, Intranet_on, Intra_sig_start, busy, done, err
  );

  modport slave (
    output start, cfg_rows, cfg_cols, cfg_k, cfg_bias_en, cfg_a_base, cfg_w_base,
           cfg_o_base, cfg_xfer_a_base, bias_data, bias_valid, Intra_sig_end,
    input  bias_ready, mode, a_buf_on, w_buf_on, a_base_addr, w_base_addr, o_base_addr,
           Intra_O_base_addr, Intra_A_base_addr, a_num_rows, w_num_cols,
           operation_signal_in, w_en_bias, w_index_bias, w_data_bias, o_ag_o_on,
           sa_reset, Intranet_on, Intra_sig_start, busy, done, err
  );
endinterface

// File: rtl/tile_op_sequencer.sv
// Control FSM running one output-stationary tile: bias load, flow, skew flush,
// drain, store, accumulator clear and O-to-A transfer. All outputs registered.
module tile_op_sequencer #(
  parameter int unsigned ARRAY_N      = 16,
  parameter int unsigned ARRAY_M      = 16,
  parameter int unsigned PE_OUT_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned XFER_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  tile_op_sequencer_if.master bus
);
  localparam int unsigned ROW_W = $clog2(ARRAY_N) + 1;
  localparam int unsigned COL_W = $clog2(ARRAY_M) + 1;
  localparam int unsigned CNT_W = 32;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_BIAS  = 4'd1;
  localparam logic [3:0] S_FLOW  = 4'd2;
  localparam logic [3:0] S_SKEW  = 4'd3;
  localparam logic [3:0] S_DWAIT = 4'd4;
  localparam logic [3:0] S_STORE = 4'd5;
  localparam logic [3:0] S_GAP   = 4'd6;
  localparam logic [3:0] S_CLEAR = 4'd7;
  localparam logic [3:0] S_XFER  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_FLOW  = 3'b100;
  localparam logic [2:0] OP_DRAIN = 3'b110;

  logic [3:0]              state, nxt;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [ROW_W-1:0]        rows_q, rows_e;
  logic [COL_W-1:0]        cols_q, cols_e;
  logic [31:0]             k_q, k_e;
  logic [ADDR_WIDTH-1:0]   a_q, w_q, o_q, x_q, a_e, w_e, o_e, x_e;
  logic                    accept, dim_ok, act_d, beat, err_d;
  logic [2:0]              op_d;

  // In IDLE the effective config is the command input; otherwise the latched copy.
  always_comb begin
    if (state == S_IDLE) begin
      rows_e = bus.cfg_rows;   cols_e = bus.cfg_cols;   k_e = bus.cfg_k;
      a_e    = bus.cfg_a_base; w_e    = bus.cfg_w_base;
      o_e    = bus.cfg_o_base; x_e    = bus.cfg_xfer_a_base;
    end else begin
      rows_e = rows_q; cols_e = cols_q; k_e = k_q;
      a_e    = a_q;    w_e    = w_q;    o_e = o_q; x_e = x_q;
    end
  end

  assign dim_ok = (rows_e != '0) && (CNT_W'(rows_e) <= CNT_W'(ARRAY_N)) &&
                  (cols_e != '0) && (CNT_W'(cols_e) <= CNT_W'(ARRAY_M));
  assign beat   = (state == S_BIAS) && bus.bias_valid;

  // Next state, phase counter and next registered output values.
  always_comb begin
    nxt    = state;
    cnt_d  = cnt;
    accept = 1'b0;
    err_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (dim_ok) begin
            accept = 1'b1;
            if (bus.cfg_bias_en)       nxt = S_BIAS;
            else if (bus.cfg_k == '0) nxt = S_SKEW;
            else                       nxt = S_FLOW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_BIAS: begin
        if (beat) begin
          if (cnt == CNT_W'(ARRAY_M - 1)) nxt = (k_e == '0) ? S_SKEW : S_FLOW;
          else                            cnt_d = cnt + CNT_W'(1);
        end
      end
      S_FLOW:  if (cnt == '0) nxt = S_SKEW;  else cnt_d = cnt - CNT_W'(1);
      S_SKEW:  if (cnt == '0) nxt = S_DWAIT; else cnt_d = cnt - CNT_W'(1);
      S_DWAIT: if (cnt == '0) nxt = S_STORE; else cnt_d = cnt - CNT_W'(1);
      S_STORE: if (cnt == '0) nxt = S_GAP;   else cnt_d = cnt - CNT_W'(1);
      S_GAP:   nxt = S_CLEAR;
      S_CLEAR: nxt = S_XFER;
      S_XFER: begin
        if (bus.Intra_sig_end) begin
          nxt = S_DONE;
        end else if (cnt == '0) begin
          nxt   = S_IDLE;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase

    // Down-counters load length-1 on entry; BIAS counts beats upward from 0.
    if (nxt != state) begin
      case (nxt)
        S_FLOW:  cnt_d = k_e - 32'd1;
        S_SKEW:  cnt_d = CNT_W'(rows_e) + CNT_W'(cols_e) - CNT_W'(2);
        S_DWAIT: cnt_d = CNT_W'(ARRAY_N) - CNT_W'(rows_e);
        S_STORE: cnt_d = CNT_W'(rows_e);
        S_XFER:  cnt_d = CNT_W'(XFER_TIMEOUT - 1);
        default: cnt_d = '0;
      endcase
    end

    act_d = (nxt != S_IDLE);
    case (nxt)
      S_FLOW, S_SKEW:   op_d = OP_FLOW;
      S_DWAIT, S_STORE: op_d = OP_DRAIN;
      default:          op_d = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= S_IDLE;
      cnt                     <= '0;
      rows_q                  <= '0;
      cols_q                  <= '0;
      k_q                     <= '0;
      a_q                     <= '0;
      w_q                     <= '0;
      o_q                     <= '0;
      x_q                     <= '0;
      bus.mode                <= 1'b0;
      bus.busy                <= 1'b0;
      bus.bias_ready          <= 1'b0;
      bus.a_buf_on            <= 1'b0;
      bus.w_buf_on            <= 1'b0;
      bus.operation_signal_in <= OP_IDLE;
      bus.o_ag_o_on           <= 1'b0;
      bus.sa_reset            <= 1'b0;
      bus.Intranet_on         <= 1'b0;
      bus.Intra_sig_start     <= 1'b0;
      bus.done                <= 1'b0;
      bus.err                 <= 1'b0;
      bus.w_en_bias           <= 1'b0;
      bus.w_index_bias        <= '0;
      bus.w_data_bias         <= '0;
      bus.a_base_addr         <= '0;
      bus.w_base_addr         <= '0;
      bus.o_base_addr         <= '0;
      bus.Intra_O_base_addr   <= '0;
      bus.Intra_A_base_addr   <= '0;
      bus.a_num_rows          <= '0;
      bus.w_num_cols          <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
      if (accept) begin
        rows_q <= bus.cfg_rows;
        cols_q <= bus.cfg_cols;
        k_q    <= bus.cfg_k;
        a_q    <= bus.cfg_a_base;
        w_q    <= bus.cfg_w_base;
        o_q    <= bus.cfg_o_base;
        x_q    <= bus.cfg_xfer_a_base;
      end
      bus.mode                <= act_d;
      bus.busy                <= act_d;
      bus.bias_ready          <= (nxt == S_BIAS);
      bus.a_buf_on            <= (nxt == S_FLOW);
      bus.w_buf_on            <= (nxt == S_FLOW);
      bus.operation_signal_in <= op_d;
      bus.o_ag_o_on           <= (nxt == S_STORE);
      bus.sa_reset            <= (nxt == S_CLEAR);
      bus.Intranet_on         <= (nxt == S_XFER);
      bus.Intra_sig_start     <= (nxt == S_XFER);
      bus.done                <= (nxt == S_DONE);
      bus.err                 <= err_d;
      // Accepted bias beats are written one cycle after the handshake.
      bus.w_en_bias           <= beat;
      bus.w_index_bias        <= beat ? COL_W'(cnt) : '0;
      bus.w_data_bias         <= beat ? bus.bias_data : '0;
      bus.a_base_addr         <= act_d ? a_e    : '0;
      bus.w_base_addr         <= act_d ? w_e    : '0;
      bus.o_base_addr         <= act_d ? o_e    : '0;
      bus.Intra_O_base_addr   <= act_d ? o_e    : '0;
      bus.Intra_A_base_addr   <= act_d ? x_e    : '0;
      bus.a_num_rows          <= act_d ? rows_e : '0;
      bus.w_num_cols          <= act_d ? cols_e : '0;
    end
  end
endmodule
